// File: rtl/fifo_buffer_pkg.sv
// Shared definitions for the synchronous FIFO: default geometry and the
// per-cycle operation encoding used by the occupancy counter.
package fifo_buffer_pkg;

    localparam int FIFO_DATA_SIZE = 6;
    localparam int FIFO_ADDR_SIZE = 3;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Collapses the accepted push/pop pair into a single operation code.
    function automatic fifo_op_e decode_op(input logic push_acc, input logic pop_acc);
        return fifo_op_e'({push_acc, pop_acc});
    endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Storage is never reset; only the read register is.
module dp_ram #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem_r [0:DEPTH-1];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read; a same-address write in the same cycle returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_buffer.sv
// Synchronous FIFO: pointers, occupancy counter, status decode and sticky
// error flags around a dual-port RAM with registered read.
module fifo_buffer
    import fifo_buffer_pkg::*;
#(
    parameter int DATA_SIZE = FIFO_DATA_SIZE,
    parameter int ADDR_SIZE = FIFO_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic [ADDR_SIZE:0]   umbral_alto,
    input  logic [ADDR_SIZE:0]   umbral_bajo,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow,
    output logic [ADDR_SIZE:0]   fifo_count
);

    localparam int                 DEPTH   = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE + 1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] CNT_ONE = (ADDR_SIZE + 1)'(1);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

    logic [ADDR_SIZE-1:0] wr_ptr_r;
    logic [ADDR_SIZE-1:0] rd_ptr_r;
    logic [ADDR_SIZE:0]   count_r;
    logic [ADDR_SIZE:0]   count_nxt_s;
    logic                 push_acc_s;
    logic                 pop_acc_s;
    logic                 ovf_evt_s;
    logic                 udf_evt_s;
    fifo_op_e             op_s;
    logic                 valid_r;
    logic                 overflow_r;
    logic                 underflow_r;

    // Status flags decode only from the registered occupancy.
    assign full         = (count_r == DEPTH_C);
    assign empty        = (count_r == '0);
    assign almost_full  = (count_r >= umbral_alto);
    assign almost_empty = (count_r <= umbral_bajo);
    assign fifo_count   = count_r;
    assign valid_out    = valid_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

    // Request acceptance and next occupancy; a pop frees a slot for a push on full.
    always_comb begin
        push_acc_s  = push && (!full || pop);
        pop_acc_s   = pop && !empty;
        ovf_evt_s   = push && full && !pop;
        udf_evt_s   = pop && empty;
        op_s        = decode_op(push_acc_s, pop_acc_s);
        count_nxt_s = count_r;
        case (op_s)
            OP_PUSH: count_nxt_s = count_r + CNT_ONE;
            OP_POP:  count_nxt_s = count_r - CNT_ONE;
            OP_BOTH: count_nxt_s = count_r;
            OP_IDLE: count_nxt_s = count_r;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, occupancy, read-valid and sticky error registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            valid_r     <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_nxt_s;
            valid_r     <= pop_acc_s;
            overflow_r  <= overflow_r | ovf_evt_s;
            underflow_r <= underflow_r | udf_evt_s;
        end
    end

    dp_ram #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset_L),
        .wr_en   (push_acc_s),
        .wr_addr (wr_ptr_r),
        .wr_data (data_in),
        .rd_en   (pop_acc_s),
        .rd_addr (rd_ptr_r),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed, table-driven bench for fifo_buffer plus hand-written sequences
// for mid-cycle reset and threshold corner cases.
module tb_fifo_buffer;

    localparam int DW = 6;
    localparam int AW = 3;

    logic          clk;
    logic          reset_L;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [AW:0]   umbral_alto;
    logic [AW:0]   umbral_bajo;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;
    logic [AW:0]   fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          push;
        logic          pop;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        logic          valid;
        logic [AW:0]   cnt;
        logic          ovf;
        logic          udf;
    } vec_t;

    vec_t vecs[$];

    fifo_buffer #(
        .DATA_SIZE (DW),
        .ADDR_SIZE (AW)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [DW-1:0] dout, input logic valid,
                             input logic [AW:0] cnt, input logic ovf, input logic udf);
        check({tag, ".data_out"},     32'(data_out),     32'(dout));
        check({tag, ".valid_out"},    32'(valid_out),    32'(valid));
        check({tag, ".fifo_count"},   32'(fifo_count),   32'(cnt));
        check({tag, ".full"},         32'(full),         32'(cnt == 4'd8));
        check({tag, ".empty"},        32'(empty),        32'(cnt == 4'd0));
        check({tag, ".almost_full"},  32'(almost_full),  32'(cnt >= umbral_alto));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(cnt <= umbral_bajo));
        check({tag, ".overflow"},     32'(overflow),     32'(ovf));
        check({tag, ".underflow"},    32'(underflow),    32'(udf));
    endtask

    task automatic add(input logic p, input logic q, input logic [DW-1:0] din,
                       input logic [DW-1:0] dout, input logic v, input logic [AW:0] c,
                       input logic o, input logic u);
        vec_t t;
        t.push = p; t.pop = q; t.din = din; t.dout = dout;
        t.valid = v; t.cnt = c; t.ovf = o; t.udf = u;
        vecs.push_back(t);
    endtask

    task automatic step(input logic p, input logic q, input logic [DW-1:0] din);
        push    = p;
        pop     = q;
        data_in = din;
        @(posedge clk);
        @(negedge clk);
        push    = 1'b0;
        pop     = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] prev_d;
        reset_L     = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        data_in     = '0;
        umbral_alto = 4'd6;
        umbral_bajo = 4'd2;

        // Fill 0x01..0x08, then full push+pop, then rejected push.
        for (int k = 1; k <= 8; k++) add(1'b1, 1'b0, DW'(k), 6'h00, 1'b0, 4'(k), 1'b0, 1'b0);
        add(1'b1, 1'b1, 6'h3F, 6'h01, 1'b1, 4'd8, 1'b0, 1'b0);
        add(1'b1, 1'b0, 6'h15, 6'h01, 1'b0, 4'd8, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++)
            add(1'b0, 1'b1, 6'h00, (j < 7) ? DW'(j + 2) : 6'h3F, 1'b1, 4'(7 - j), 1'b1, 1'b0);
        add(1'b0, 1'b1, 6'h00, 6'h3F, 1'b0, 4'd0, 1'b1, 1'b1);
        add(1'b1, 1'b1, 6'h11, 6'h3F, 1'b0, 4'd1, 1'b1, 1'b1);
        add(1'b0, 1'b1, 6'h00, 6'h11, 1'b1, 4'd0, 1'b1, 1'b1);
        prev_d = 6'h11;
        for (int i = 0; i < 12; i++) begin
            add(1'b1, 1'b0, DW'(6'h20 + i), prev_d, 1'b0, 4'd1, 1'b1, 1'b1);
            add(1'b0, 1'b1, 6'h00, DW'(6'h20 + i), 1'b1, 4'd0, 1'b1, 1'b1);
            prev_d = DW'(6'h20 + i);
        end

        repeat (2) @(negedge clk);
        check_all("reset", 6'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        reset_L = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].din);
            check_all($sformatf("v%0d", i), vecs[i].dout, vecs[i].valid, vecs[i].cnt,
                      vecs[i].ovf, vecs[i].udf);
        end

        // Asynchronous reset between edges with five words queued.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, DW'(6'h30 + k));
        check_all("pre_rst", 6'h2B, 1'b0, 4'd5, 1'b1, 1'b1);
        #2;
        reset_L     = 1'b0;
        umbral_alto = 4'd0;
        #1;
        check_all("mid_rst", 6'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        check("mid_rst.af_zero_thr", 32'(almost_full), 32'd1);
        umbral_alto = 4'd6;
        @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        step(1'b1, 1'b0, 6'h2A);
        check_all("post_rst_push", 6'h00, 1'b0, 4'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'h00);
        check_all("post_rst_pop", 6'h2A, 1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'h00);
        check_all("idle_hold", 6'h2A, 1'b0, 4'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
